// File: rtl/word_serializer.sv
// word_serializer: word-to-byte serializer with a two-entry store
// (active shift register plus one pending word) for bubble-free output.
// Optional feature macro: WSER_PARTIAL_EN (per-word truncated beat count).
module word_serializer #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  localparam int unsigned N_BYTES   = WORD_WIDTH / BYTE_WIDTH,
  localparam int unsigned CNT_W     = $clog2(N_BYTES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic                  i_word_valid,
  input  logic [WORD_WIDTH-1:0] i_word,
`ifdef WSER_PARTIAL_EN
  input  logic [CNT_W-1:0]      i_word_nbytes,
`endif
  output logic                  o_word_ready,
  output logic                  o_byte_valid,
  output logic [BYTE_WIDTH-1:0] o_byte,
  output logic                  o_last,
  input  logic                  i_byte_ready,
  output logic                  o_empty
);

  if ((WORD_WIDTH % BYTE_WIDTH) != 0) begin : g_width_chk
    $error("word_serializer: WORD_WIDTH must be a multiple of BYTE_WIDTH");
  end

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] act_q, act_d, pend_q, pend_d, act_shift;
  logic [CNT_W-1:0]      cnt_q, cnt_d, pend_n_q, pend_n_d, nb_in;
  logic                  pend_v_q, pend_v_d;
  logic                  word_acc, beat_acc;

  // Beat count carried by an incoming word; 0 or out-of-range means a full word
`ifdef WSER_PARTIAL_EN
  assign nb_in = ((i_word_nbytes == '0) || (i_word_nbytes > CNT_W'(N_BYTES)))
               ? CNT_W'(N_BYTES) : i_word_nbytes;
`else
  assign nb_in = CNT_W'(N_BYTES);
`endif

  // Status outputs depend on registered state only
  assign o_word_ready = ~pend_v_q;
  assign o_byte_valid = (state_q == SHIFT);
  assign o_last       = (cnt_q == CNT_W'(1));
  assign o_empty      = (state_q == IDLE) & ~pend_v_q;

  // A word offered during flush is dropped
  assign word_acc = i_word_valid & ~pend_v_q & ~i_flush;
  assign beat_acc = o_byte_valid & i_byte_ready;

  // Output end of the active register and the matching shift direction
  if (MSB_FIRST) begin : g_msb
    assign o_byte    = o_byte_valid ? act_q[WORD_WIDTH-1 -: BYTE_WIDTH] : '0;
    assign act_shift = act_q << BYTE_WIDTH;
  end else begin : g_lsb
    assign o_byte    = o_byte_valid ? act_q[BYTE_WIDTH-1:0] : '0;
    assign act_shift = act_q >> BYTE_WIDTH;
  end

  // State and storage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      act_q    <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      pend_n_q <= '0;
      pend_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      act_q    <= act_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      pend_n_q <= pend_n_d;
      pend_v_q <= pend_v_d;
    end
  end

  // Next-state: load, shift, hand-over from pending, and flush
  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    pend_n_d = pend_n_q;
    pend_v_d = pend_v_q;
    if (i_flush) begin
      state_d  = IDLE;
      act_d    = '0;
      cnt_d    = '0;
      pend_v_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (word_acc) begin
            act_d   = i_word;
            cnt_d   = nb_in;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (beat_acc && (cnt_q == CNT_W'(1))) begin
            if (pend_v_q) begin
              act_d    = pend_q;
              cnt_d    = pend_n_q;
              pend_v_d = word_acc;
              if (word_acc) begin
                pend_d   = i_word;
                pend_n_d = nb_in;
              end
            end else if (word_acc) begin
              act_d = i_word;
              cnt_d = nb_in;
            end else begin
              act_d   = '0;
              cnt_d   = '0;
              state_d = IDLE;
            end
          end else begin
            if (beat_acc) begin
              act_d = act_shift;
              cnt_d = cnt_q - CNT_W'(1);
            end
            if (word_acc) begin
              pend_d   = i_word;
              pend_n_d = nb_in;
              pend_v_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
